// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
interface instruction_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              MemReq;
   logic [ADDR_W-1:0] MemAddr;
   logic              MemAck;
   logic [DATA_W-1:0] MemData;

   modport master (
      output MemReq,
      output MemAddr,
      input  MemAck,
      input  MemData
   );

   modport slave (
      input  MemReq,
      input  MemAddr,
      output MemAck,
      output MemData
   );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: samples the PC, runs one req/ack memory read per fetch, holds the
// word for decode, stalls the PC while busy and flags consumed break instructions.
module instruction_fetch #(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter int                TIMEOUT      = 16,
   parameter logic [5:0]        BREAK_OPCODE = 6'b001101,
   parameter logic [DATA_W-1:0] NOP_INSTR    = '0
) (
   input  logic                clock,
   input  logic                Reset,
   input  logic [ADDR_W-1:0]   PC,
   output logic                StallPC,
   output logic                BreakFlag,
   input  logic                Flush,
   instruction_fetch_if.master mem,
   output logic [DATA_W-1:0]   Instr,
   output logic [ADDR_W-1:0]   InstrPC,
   output logic                InstrValid,
   input  logic                DecodeReady,
   output logic                FetchErr
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, ERROR} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [TW-1:0]     timer;
   logic              drop;
   logic              brk_hit;

   assign mem.MemReq  = mem_req;
   assign mem.MemAddr = mem_addr;

   always_ff @(posedge clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  state_nxt = REQ;
         REQ: begin
            if (mem.MemAck)          state_nxt = (drop || Flush) ? IDLE : HOLD;
            else if (timer == T_LAST) state_nxt = ERROR;
         end
         HOLD:  if (Flush || DecodeReady) state_nxt = IDLE;
         ERROR: state_nxt = ERROR;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      StallPC = (state != IDLE);
      brk_hit = (state == HOLD) && !Flush && DecodeReady &&
                (Instr[31:26] == BREAK_OPCODE);
   end

   // A flush during an outstanding request cannot cancel the handshake, so it
   // is remembered in drop and the eventual acknowledge is thrown away.
   always_ff @(posedge clock) begin
      if (Reset) begin
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         Instr      <= NOP_INSTR;
         InstrPC    <= '0;
         InstrValid <= 1'b0;
         BreakFlag  <= 1'b0;
         FetchErr   <= 1'b0;
         timer      <= '0;
         drop       <= 1'b0;
      end else begin
         BreakFlag <= brk_hit;
         case (state)
            IDLE: begin
               mem_addr <= PC;
               mem_req  <= 1'b1;
               timer    <= '0;
               drop     <= 1'b0;
            end
            REQ: begin
               if (mem.MemAck) begin
                  mem_req <= 1'b0;
                  if (!drop && !Flush) begin
                     Instr      <= mem.MemData;
                     InstrPC    <= mem_addr;
                     InstrValid <= 1'b1;
                  end
               end else begin
                  if (Flush) drop <= 1'b1;
                  if (timer == T_LAST) begin
                     mem_req  <= 1'b0;
                     FetchErr <= 1'b1;
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
            end
            HOLD: begin
               if (Flush || DecodeReady) begin
                  InstrValid <= 1'b0;
                  Instr      <= NOP_INSTR;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized self-checking bench for instruction_fetch against a fetch-level
// reference model, plus directed scenarios for latency, flush, break and timeout.
module tb_instruction_fetch;

   localparam int TIMEOUT = 16;
   localparam logic [5:0] BRK = 6'b001101;

   logic        clock;
   logic        rst;
   logic [31:0] pc;
   logic        stall_pc;
   logic        break_flag;
   logic        flush;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        ready;
   logic        fetch_err;

   int n_tests;
   int n_fail;

   instruction_fetch_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

   instruction_fetch #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT),
      .BREAK_OPCODE(BRK), .NOP_INSTR(32'h0)
   ) dut (
      .clock(clock),
      .Reset(rst),
      .PC(pc),
      .StallPC(stall_pc),
      .BreakFlag(break_flag),
      .Flush(flush),
      .mem(mem_bus.master),
      .Instr(instr),
      .InstrPC(instr_pc),
      .InstrValid(instr_valid),
      .DecodeReady(ready),
      .FetchErr(fetch_err)
   );

   always #5 clock = ~clock;

   // Reference model: where the fetch is (waiting for PC, waiting on memory,
   // waiting on decode, dead) plus what each output should show.
   typedef enum int {W_PC, W_MEM, W_DEC, DEAD} phase_t;
   phase_t      m_phase;
   logic        m_req;
   logic [31:0] m_addr;
   logic [31:0] m_instr;
   logic [31:0] m_ipc;
   logic        m_valid;
   logic        m_brk;
   logic        m_err;
   int          m_waits;
   logic        m_cancelled;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      logic ack;
      ack = mem_bus.MemAck;
      m_brk = 1'b0;
      if (rst) begin
         m_phase = W_PC; m_req = 0; m_addr = 0; m_instr = 0; m_ipc = 0;
         m_valid = 0; m_err = 0; m_waits = 0; m_cancelled = 0;
      end else if (m_phase == W_PC) begin
         m_addr = pc; m_req = 1; m_waits = 0; m_cancelled = 0; m_phase = W_MEM;
      end else if (m_phase == W_MEM) begin
         if (ack) begin
            m_req = 0;
            if (m_cancelled || flush) m_phase = W_PC;
            else begin
               m_instr = mem_bus.MemData; m_ipc = m_addr; m_valid = 1; m_phase = W_DEC;
            end
         end else begin
            if (flush) m_cancelled = 1;
            m_waits++;
            if (m_waits == TIMEOUT) begin
               m_req = 0; m_err = 1; m_phase = DEAD;
            end
         end
      end else if (m_phase == W_DEC) begin
         if (flush || ready) begin
            m_brk = !flush && (m_instr[31:26] == BRK);
            m_valid = 0; m_instr = 0; m_phase = W_PC;
         end
      end
   endtask

   task automatic compare_all();
      check("StallPC", 64'(stall_pc), 64'(m_phase != W_PC));
      check("MemReq", 64'(mem_bus.MemReq), 64'(m_req));
      check("MemAddr", 64'(mem_bus.MemAddr), 64'(m_addr));
      check("InstrValid", 64'(instr_valid), 64'(m_valid));
      check("Instr", 64'(instr), 64'(m_instr));
      check("InstrPC", 64'(instr_pc), 64'(m_ipc));
      check("BreakFlag", 64'(break_flag), 64'(m_brk));
      check("FetchErr", 64'(fetch_err), 64'(m_err));
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      compare_all();
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      clock = 0; rst = 1; pc = 0; flush = 0; ready = 0;
      mem_bus.MemAck = 0; mem_bus.MemData = 0;
      m_phase = W_PC; m_req = 0; m_addr = 0; m_instr = 0; m_ipc = 0;
      m_valid = 0; m_brk = 0; m_err = 0; m_waits = 0; m_cancelled = 0;

      tick(); tick();
      check("rst_valid", 64'(instr_valid), 64'd0);
      check("rst_stall", 64'(stall_pc), 64'd0);
      check("rst_instr", 64'(instr), 64'd0);

      // zero-wait fetch at 0x40
      rst = 0; pc = 32'h40;
      tick();
      check("req_addr", 64'(mem_bus.MemAddr), 64'h40);
      mem_bus.MemAck = 1; mem_bus.MemData = 32'h8C220004;
      tick();
      mem_bus.MemAck = 0;
      check("first_instr", 64'(instr), 64'h8C220004);
      check("first_ipc", 64'(instr_pc), 64'h40);
      check("first_valid", 64'(instr_valid), 64'd1);

      // back-pressure
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_stall", 64'(stall_pc), 64'd1);
      end
      ready = 1;
      tick();
      ready = 0;
      check("bp_release", 64'(instr_valid), 64'd0);
      check("bp_idle", 64'(stall_pc), 64'd0);

      // flush at wait cycle 2, ack at wait cycle 4
      pc = 32'h100;
      tick();
      tick();
      flush = 1; tick(); flush = 0;
      tick();
      mem_bus.MemAck = 1; mem_bus.MemData = 32'h12345678;
      tick();
      mem_bus.MemAck = 0;
      check("flush_novalid", 64'(instr_valid), 64'd0);
      check("flush_idle", 64'(stall_pc), 64'd0);
      pc = 32'h200;
      tick();
      check("flush_newaddr", 64'(mem_bus.MemAddr), 64'h200);

      // break word consumed
      mem_bus.MemAck = 1; mem_bus.MemData = 32'h34000000;
      tick();
      mem_bus.MemAck = 0; ready = 1;
      tick();
      ready = 0;
      check("brk_pulse", 64'(break_flag), 64'd1);
      tick();
      check("brk_clear", 64'(break_flag), 64'd0);
      mem_bus.MemAck = 1; mem_bus.MemData = 32'h8C220004;
      tick();
      mem_bus.MemAck = 0; ready = 1;
      tick();
      ready = 0;
      check("nobrk", 64'(break_flag), 64'd0);

      // reset mid-request with an acknowledge pending
      tick();
      rst = 1; mem_bus.MemAck = 1; mem_bus.MemData = 32'hDEADBEEF;
      tick();
      rst = 0; mem_bus.MemAck = 0;
      check("rstreq_valid", 64'(instr_valid), 64'd0);
      check("rstreq_instr", 64'(instr), 64'd0);
      check("rstreq_req", 64'(mem_bus.MemReq), 64'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         pc      = $urandom;
         flush   = ($urandom_range(0, 7) == 0);
         ready   = $urandom_range(0, 1);
         rst     = ($urandom_range(0, 149) == 0);
         mem_bus.MemAck  = m_req && ($urandom_range(0, 2) == 0);
         mem_bus.MemData = ($urandom_range(0, 3) == 0) ? {BRK, 26'($urandom)} : $urandom;
         tick();
      end
      flush = 0; ready = 0; mem_bus.MemAck = 0;

      // memory timeout
      rst = 1; tick(); rst = 0;
      tick();
      for (int i = 0; i < TIMEOUT - 1; i++) tick();
      check("to_before", 64'(fetch_err), 64'd0);
      tick();
      check("to_err", 64'(fetch_err), 64'd1);
      check("to_req", 64'(mem_bus.MemReq), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("to_stall", 64'(stall_pc), 64'd1);
      end
      rst = 1; tick(); rst = 0;
      check("to_rst_err", 64'(fetch_err), 64'd0);
      check("to_rst_idle", 64'(stall_pc), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly downstream of the program counter. It samples the current PC, runs a req/ack read on instruction memory, and holds the returned word for decode until decode accepts it. It drives StallPC to freeze the PC while a fetch is outstanding. It also raises a one-cycle BreakFlag toward the PC when a break instruction is consumed.

Parameters:
ADDR_W, 32, address/PC width
DATA_W, 32, instruction width
TIMEOUT, 16, max cycles in REQ without MemAck before error (>=2)
BREAK_OPCODE, 6'b001101, value of Instr[31:26] that marks a break instruction
NOP_INSTR, 32'h00000000, value presented on Instr when nothing valid

Ports:
clock  in  1  single clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
PC  in  ADDR_W  current PC value (program counter output)
StallPC  out  1  1 = PC must hold; combinational from state
BreakFlag  out  1  registered one-cycle pulse when a break instruction is consumed
Flush  in  1  branch redirect; discard in-flight/held instruction
MemReq  out  1  instruction memory request
MemAddr  out  ADDR_W  request address, stable while MemReq=1
MemAck  in  1  memory response strobe, valid only while MemReq=1
MemData  in  DATA_W  instruction word, valid with MemAck
Instr  out  DATA_W  instruction to decode
InstrPC  out  ADDR_W  address of Instr
InstrValid  out  1  Instr/InstrPC valid
DecodeReady  in  1  decode accepts Instr this cycle
FetchErr  out  1  sticky memory-timeout error

Behaviour:
- Reset values (edge with Reset=1): state IDLE, MemReq 0, MemAddr 0, Instr NOP_INSTR, InstrPC 0, InstrValid 0, BreakFlag 0, FetchErr 0, timer 0, drop 0. Reset has priority over every other input in every state, including mid-request. Any pending MemAck is ignored.
- StallPC = 1 in REQ, HOLD and ERROR; 0 only in IDLE. The PC therefore advances exactly once per fetch.
- IDLE: on the next edge, MemAddr<=PC, MemReq<=1, timer<=0, drop<=0, go to REQ. Flush has no effect here.
- REQ: MemReq=1 and MemAddr are held constant until the request ends.
  - MemAck=1 with drop=0 and no Flush: Instr<=MemData, InstrPC<=MemAddr, InstrValid<=1, MemReq<=0, go to HOLD.
  - MemAck=1 with drop=1 or Flush=1 in the same cycle: data discarded, MemReq<=0, go to IDLE.
  - Flush=1 without MemAck: drop<=1, stay in REQ. The handshake is never abandoned.
  - No MemAck: timer<=timer+1. If timer==TIMEOUT-1: MemReq<=0, FetchErr<=1, go to ERROR. The timeout applies even when drop=1.
- HOLD: InstrValid=1 and Instr/InstrPC stable.
  - Flush=1 (priority over DecodeReady): InstrValid<=0, Instr<=NOP_INSTR, go to IDLE.
  - DecodeReady=1: InstrValid<=0, Instr<=NOP_INSTR, go to IDLE. BreakFlag<=1 on this edge if Instr[31:26]==BREAK_OPCODE.
- BreakFlag is high for exactly one cycle and cleared on the following edge.
- ERROR: MemReq 0, InstrValid 0, StallPC 1. Leaves only via Reset.
- Latency: PC sample to InstrValid = 2 cycles with zero-wait memory (MemAck in first REQ cycle). Minimum fetch period is 3 cycles (IDLE, REQ, HOLD).
- Timer width is clog2(TIMEOUT). It has no wrap-around because ERROR is entered at TIMEOUT-1.

Test Plan:
- Reset then PC=0x40, MemAck with MemData=0x8C220004 in first REQ cycle -> MemAddr=0x40, InstrValid=1 two cycles after IDLE with Instr=0x8C220004, InstrPC=0x40; StallPC=1 until DecodeReady.
- Back-pressure: hold DecodeReady=0 for 5 cycles -> Instr/InstrValid unchanged, StallPC=1 throughout; DecodeReady=1 -> InstrValid=0 next cycle, state IDLE.
- Flush in REQ at wait cycle 2, MemAck at wait cycle 4 -> MemReq held until ack, InstrValid never rises, return to IDLE, next MemAddr = new PC.
- Break: MemData=0x34000000 consumed -> BreakFlag=1 for exactly one cycle on the consume edge+1; a non-break word gives BreakFlag=0.
- Timeout: MemAck never asserted, TIMEOUT=16 -> MemReq drops and FetchErr=1 after 16 REQ cycles, StallPC stays 1; Reset clears FetchErr=0 and returns to IDLE.
- Reset asserted mid-REQ with MemAck in the same cycle -> all outputs at reset values next cycle, data not captured.
